imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the decode-stage immediate extender: packs a 32-bit immediate into RISC-V I/S/B/U/J
//  instruction bit positions and merges it with caller-supplied non-immediate fields.
//  2-stage valid/ready pipeline: stage 1 does the range/alignment check, stage 2 packs the word.
//  Feeds self-test instruction generation and the boot-loader patcher.
// PARAMETERS
//  COUNT_W  16  width of the saturating encoded-word counter
// PORTS
//  clk         in   1        clock; all state updates on rising edge
//  rst_n       in   1        synchronous reset, active-low
//  in_valid    in   1        request valid
//  in_ready    out  1        request accepted when in_valid & in_ready
//  imm_src     in   3        000 I, 001 S, 010 B, 011 U, 100 J; same encoding as the decode immSrc
//  imm         in   32       immediate value (two's complement)
//  base_instr  in   32       opcode/rd/rs1/rs2/funct fields; bits in immediate positions ignored
//  out_valid   out  1        encoded word valid
//  out_ready   in   1        consumer accepts when out_valid & out_ready
//  instr       out  32       encoded instruction
//  out_err     out  1        word-aligned flag: range, alignment or imm_src error
//  err_sticky  out  1        set on any out handshake with out_err=1
//  clr         in   1        clears err_sticky and enc_count (lower priority than rst_n)
//  enc_count   out  COUNT_W  out handshakes since reset/clr, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pipeline flushed (both stage valids 0), out_valid=0, instr=0,
//   out_err=0, err_sticky=0, enc_count=0. In-flight requests are dropped, not completed.
//  Advance enable adv = !out_valid | out_ready; in_ready = adv (combinational).
//   If adv=0, both stages hold and instr/out_err stay stable.
//  Latency: accept at edge N -> out_valid at edge N+2 with no backpressure. Throughput 1/cycle.
//  Bubbles propagate: stage valids shift independently, so no output is duplicated.
//  Packing (bits not listed come from base_instr):
//   I: [31:20]=imm[11:0]                          err if imm[31:11] not all equal
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]         err if imm[31:11] not all equal
//   B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
//                                                 err if imm[31:12] not equal or imm[0]=1
//   U: [31:12]=imm[31:12]                         err if imm[11:0] != 0
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//                                                 err if imm[31:20] not equal or imm[0]=1
//   imm_src 101..111: err=1, instr=base_instr unchanged.
//  An erroring word is still packed with the truncated field bits and still delivered.
//  err_sticky/enc_count update on the out handshake. enc_count holds at 2^COUNT_W-1.
//  clr and an out handshake in the same cycle: clr wins; the count becomes 0, not 1.
// CONFIGURATION
//  IMM_ROUNDTRIP_CHECK_EN defined: stage 2 re-decodes instr with the decode-stage extension rules
//   and adds output rt_mismatch (1 bit, reset 0, aligned with instr). It is 1 when err=0 and the
//   re-decoded imm != imm. Any nonzero value is an RTL bug.
//  Not defined: no rt_mismatch port and no check logic.
// TESTING
//  I, imm=32'hFFFF_FFFF, base=32'h0000_0013 -> 2 cycles later instr=32'hFFF0_0013, out_err=0
//  B, imm=32'h0000_0800, base=32'h0000_0063 -> instr=32'h0000_00E3, out_err=0
//  B, imm=32'h0000_1000 -> out_err=1, err_sticky=1 after handshake; U, imm=32'h1234_5000, base=32'h37 -> 32'h1234_5037
//  J, imm=3 -> out_err=1; imm_src=3'b111, base=32'hDEAD_BEEF -> instr=32'hDEAD_BEEF, out_err=1
//  Stream 4 requests, hold out_ready=0 for 3 cycles -> in_ready=0, instr stable; no loss/dup; enc_count=4
//  rst_n=0 with 2 in flight -> next cycle out_valid=0, enc_count=0; COUNT_W=2, 5 words -> enc_count=3

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into RISC-V I/S/B/U/J bit positions and merges it with base_instr fields.
// Latency 2 cycles from the accepting edge to out_valid; throughput one word per cycle.
// Backpressure: in_ready = !out_valid | out_ready; when low, every stage holds and outputs stay stable.
// Optional build macro IMM_ROUNDTRIP_CHECK_EN adds o_rt_mismatch (re-decode self check).
module imm_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [2:0]         i_imm_src,
    input  logic [31:0]        i_imm,
    input  logic [31:0]        i_base_instr,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_instr,
    output logic               o_out_err,
    output logic               o_err_sticky,
    input  logic               i_clr,
    output logic [COUNT_W-1:0] o_enc_count
`ifdef IMM_ROUNDTRIP_CHECK_EN
    ,
    output logic               o_rt_mismatch
`endif
);
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    logic               w_adv;
    logic               w_out_hs;
    logic               w_chk_err;
    logic [31:0]        w_pack;

    logic               r_s1_vld;
    logic [2:0]         r_s1_src;
    logic [31:0]        r_s1_imm;
    logic [31:0]        r_s1_base;
    logic               r_s1_err;
    logic               r_s2_vld;
    logic [31:0]        r_s2_instr;
    logic               r_s2_err;
    logic               r_out_vld;
    logic [31:0]        r_out_instr;
    logic               r_out_err;
    logic               r_err_sticky;
    logic [COUNT_W-1:0] r_enc_count;

    assign w_adv      = !r_out_vld || i_out_ready;
    assign w_out_hs   = r_out_vld && i_out_ready;
    assign o_in_ready = w_adv;

    // Range / alignment check on the incoming request: the immediate must fit the field once sign-extended.
    always_comb begin
        w_chk_err = 1'b1;
        case (i_imm_src)
            SRC_I, SRC_S: w_chk_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            SRC_B:        w_chk_err = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
            SRC_U:        w_chk_err = |i_imm[11:0];
            SRC_J:        w_chk_err = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
            default:      w_chk_err = 1'b1;
        endcase
    end

    // Scatter the truncated immediate into the format's bit positions; other bits come from base.
    always_comb begin
        w_pack = r_s1_base;
        case (r_s1_src)
            SRC_I: w_pack = {r_s1_imm[11:0], r_s1_base[19:0]};
            SRC_S: w_pack = {r_s1_imm[11:5], r_s1_base[24:12], r_s1_imm[4:0], r_s1_base[6:0]};
            SRC_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_base[24:12],
                             r_s1_imm[4:1], r_s1_imm[11], r_s1_base[6:0]};
            SRC_U: w_pack = {r_s1_imm[31:12], r_s1_base[11:0]};
            SRC_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                             r_s1_imm[19:12], r_s1_base[11:0]};
            default: w_pack = r_s1_base;
        endcase
    end

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic [31:0] w_dec;
    logic        w_rt_mismatch;
    logic        r_s2_rt;
    logic        r_out_rt;

    // Re-extend the packed word exactly as the decode stage would, to catch packing bugs.
    always_comb begin
        w_dec = r_s1_imm;
        case (r_s1_src)
            SRC_I: w_dec = {{20{w_pack[31]}}, w_pack[31:20]};
            SRC_S: w_dec = {{20{w_pack[31]}}, w_pack[31:25], w_pack[11:7]};
            SRC_B: w_dec = {{19{w_pack[31]}}, w_pack[31], w_pack[7], w_pack[30:25], w_pack[11:8], 1'b0};
            SRC_U: w_dec = {w_pack[31:12], 12'b0};
            SRC_J: w_dec = {{11{w_pack[31]}}, w_pack[31], w_pack[19:12], w_pack[20], w_pack[30:21], 1'b0};
            default: w_dec = r_s1_imm;
        endcase
    end
    assign w_rt_mismatch = !r_s1_err && (w_dec != r_s1_imm);

    // Carry the self-check flag alongside the packed word so it stays aligned with o_instr.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s2_rt  <= 1'b0;
            r_out_rt <= 1'b0;
        end else if (w_adv) begin
            if (r_s1_vld) r_s2_rt  <= w_rt_mismatch;
            if (r_s2_vld) r_out_rt <= r_s2_rt;
        end
    end
    assign o_rt_mismatch = r_out_rt;
`endif

    // Pipeline: capture+check, pack, output register; valids shift independently so bubbles pass through.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_src    <= SRC_I;
            r_s1_imm    <= '0;
            r_s1_base   <= '0;
            r_s1_err    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_instr  <= '0;
            r_s2_err    <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= i_in_valid;
            r_s2_vld  <= r_s1_vld;
            r_out_vld <= r_s2_vld;
            if (i_in_valid) begin
                r_s1_src  <= i_imm_src;
                r_s1_imm  <= i_imm;
                r_s1_base <= i_base_instr;
                r_s1_err  <= w_chk_err;
            end
            if (r_s1_vld) begin
                r_s2_instr <= w_pack;
                r_s2_err   <= r_s1_err;
            end
            if (r_s2_vld) begin
                r_out_instr <= r_s2_instr;
                r_out_err   <= r_s2_err;
            end
        end
    end

    // Sticky error and saturating word counter, both updated on the output handshake; clr overrides it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_sticky <= 1'b0;
            r_enc_count  <= '0;
        end else if (i_clr) begin
            r_err_sticky <= 1'b0;
            r_enc_count  <= '0;
        end else if (w_out_hs) begin
            r_err_sticky <= r_err_sticky || r_out_err;
            if (r_enc_count != {COUNT_W{1'b1}}) r_enc_count <= r_enc_count + 1'b1;
        end
    end

    assign o_out_valid  = r_out_vld;
    assign o_instr      = r_out_instr;
    assign o_out_err    = r_out_err;
    assign o_err_sticky = r_err_sticky;
    assign o_enc_count  = r_enc_count;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a spec-level scoreboard and a COUNT_W=2 instance for saturation.
// Expected words come from range arithmetic and field masks; literal vectors pin that model.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr = 1'b0;
    logic [2:0]  imm_src = 3'b000;
    logic [31:0] imm = '0;
    logic [31:0] base = '0;

    wire         in_ready, out_valid, out_err, err_sticky;
    wire  [31:0] instr;
    wire  [15:0] enc_count;
    wire         in_ready2, out_valid2, out_err2, err_sticky2;
    wire  [31:0] instr2;
    wire  [1:0]  enc_count2;
`ifdef IMM_ROUNDTRIP_CHECK_EN
    wire         rt, rt2;
`endif

    int errors = 0;
    int checks = 0;

    imm_encoder #(.COUNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_imm_src(imm_src), .i_imm(imm), .i_base_instr(base), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_instr(instr), .o_out_err(out_err), .o_err_sticky(err_sticky),
        .i_clr(clr), .o_enc_count(enc_count)
`ifdef IMM_ROUNDTRIP_CHECK_EN
        , .o_rt_mismatch(rt)
`endif
    );

    imm_encoder #(.COUNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
        .i_imm_src(imm_src), .i_imm(imm), .i_base_instr(base), .o_out_valid(out_valid2),
        .i_out_ready(out_ready), .o_instr(instr2), .o_out_err(out_err2), .o_err_sticky(err_sticky2),
        .i_clr(clr), .o_enc_count(enc_count2)
`ifdef IMM_ROUNDTRIP_CHECK_EN
        , .o_rt_mismatch(rt2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level model: legality by numeric range, packing by field masks. Returns {err, instr}.
    function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
        int          sv;
        logic        e;
        logic [31:0] m;
        logic [31:0] f;
        sv = $signed(v);
        e = 1'b1; m = '0; f = '0;
        case (s)
            3'd0: begin
                e = (sv < -2048) || (sv > 2047);
                m = 32'hFFF0_0000;
                f = 32'(v[11:0]) << 20;
            end
            3'd1: begin
                e = (sv < -2048) || (sv > 2047);
                m = 32'hFE00_0F80;
                f = (32'(v[11:5]) << 25) | (32'(v[4:0]) << 7);
            end
            3'd2: begin
                e = (sv < -4096) || (sv > 4095) || v[0];
                m = 32'hFE00_0F80;
                f = (32'(v[12]) << 31) | (32'(v[10:5]) << 25) | (32'(v[4:1]) << 8) | (32'(v[11]) << 7);
            end
            3'd3: begin
                e = (v[11:0] != 12'd0);
                m = 32'hFFFF_F000;
                f = v & 32'hFFFF_F000;
            end
            3'd4: begin
                e = (sv < -1048576) || (sv > 1048575) || v[0];
                m = 32'hFFFF_F000;
                f = (32'(v[20]) << 31) | (32'(v[10:1]) << 21) | (32'(v[11]) << 20) | (32'(v[19:12]) << 12);
            end
            default: begin
                e = 1'b1; m = '0; f = '0;
            end
        endcase
        return {e, (b & ~m) | f};
    endfunction

    logic [32:0] q[$];
    int          m_count = 0;
    logic        m_sticky = 1'b0;
    logic        have_hold = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_err;
    logic [32:0] exp_w;
    logic        hs_err;

    // Compare process: outputs checked every cycle, then the model advances to the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_count   = 0;
            m_sticky  = 1'b0;
            have_hold = 1'b0;
        end else begin
            chk("enc_count", 32'(enc_count), m_count);
            chk("enc_count_w2", 32'(enc_count2), (m_count > 3) ? 3 : m_count);
            chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
`ifdef IMM_ROUNDTRIP_CHECK_EN
            if (out_valid) chk("rt_mismatch", 32'(rt), 32'd0);
`endif
            if (have_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_instr", instr, hold_instr);
                chk("hold_err", 32'(out_err), 32'(hold_err));
            end
            have_hold  = out_valid && !out_ready;
            hold_instr = instr;
            hold_err   = out_err;
            hs_err     = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got instr %h with no request outstanding", instr);
                end else begin
                    exp_w = q.pop_front();
                    chk("out_instr", instr, exp_w[31:0]);
                    chk("out_err", 32'(out_err), 32'(exp_w[32]));
                    hs_err = exp_w[32];
                end
            end
            if (clr) begin
                m_count  = 0;
                m_sticky = 1'b0;
            end else if (out_valid && out_ready) begin
                if (m_count < 65535) m_count++;
                m_sticky = m_sticky | hs_err;
            end
            if (in_valid && in_ready) q.push_back(model(imm_src, imm, base));
        end
    end

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
        int k;
        imm_src = s; imm = v; base = b; in_valid = 1'b1; k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", k);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Single request with out_ready high, checked against hand-computed literals.
    task automatic xact(input string nm, input logic [2:0] s, input logic [31:0] v, input logic [31:0] b,
                        input logic [31:0] exp_i, input logic exp_e);
        int k;
        send(s, v, b);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_instr"}, instr, exp_i);
        chk({nm, "_err"}, 32'(out_err), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: accepted at edge N, visible after edge N+2.
        @(posedge clk);
        #1;
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
        @(negedge clk); chk("lat_n0", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_n1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_n2", 32'(out_valid), 32'd1);
        chk("i_neg1_instr", instr, 32'hFFF0_0013);
        chk("i_neg1_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;

        xact("b_800", 3'd2, 32'h0000_0800, 32'h0000_0063, 32'h0000_00E3, 1'b0);
        chk("sticky_clean", 32'(err_sticky), 32'd0);
        xact("b_1000", 3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1);
        @(negedge clk); chk("sticky_set", 32'(err_sticky), 32'd1);
        @(posedge clk);
        #1;
        xact("u_12345", 3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        xact("j_3", 3'd4, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1);
        xact("s_m4", 3'd1, 32'hFFFF_FFFC, 32'h0000_0023, 32'hFE00_0E23, 1'b0);
        xact("src7", 3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("count_7", 32'(enc_count), 32'd7);
        chk("count_w2_sat", 32'(enc_count2), 32'd3);

        // clr coinciding with an output handshake: clr wins, count ends at 0.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'd0, 32'h0000_0005, 32'h0000_0013);
        repeat (3) @(posedge clk);
        #1 begin out_ready = 1'b1; clr = 1'b1; end
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_wins_count", 32'(enc_count), 32'd0);
        chk("clr_wins_sticky", 32'(err_sticky), 32'd0);

        // Stream 4 requests while the consumer stalls for 3 cycles.
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(3'd0, 32'(i * 100), 32'h0000_0013);
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!out_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("stream_count", 32'(enc_count), 32'd4);
        chk("stream_count_w2", 32'(enc_count2), 32'd3);

        // Reset with two requests in flight: both dropped.
        @(posedge clk);
        #1;
        send(3'd4, 32'h0000_0800, 32'h0000_006F);
        send(3'd1, 32'h0000_0010, 32'h0000_0023);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(enc_count), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("flush_no_revive", 32'(out_valid), 32'd0);
        end

        // Range boundaries, back to back, checked by the model.
        @(posedge clk);
        #1;
        send(3'd0, 32'h0000_07FF, 32'h0000_0013);
        send(3'd0, 32'h0000_0800, 32'h0000_0013);
        send(3'd0, 32'hFFFF_F800, 32'h0000_0013);
        send(3'd1, 32'hFFFF_F7FF, 32'h0000_0023);
        send(3'd2, 32'h0000_0FFE, 32'h0000_0063);
        send(3'd2, 32'hFFFF_F000, 32'h0000_0063);
        send(3'd2, 32'h0000_0002, 32'h0000_0063);
        send(3'd4, 32'h000F_FFFE, 32'h0000_006F);
        send(3'd4, 32'h0010_0000, 32'h0000_006F);
        send(3'd4, 32'hFFF0_0000, 32'h0000_006F);
        send(3'd3, 32'hFFFF_F000, 32'h0000_0037);
        send(3'd3, 32'h0000_1001, 32'h0000_0037);
        send(3'd5, 32'h0000_0000, 32'h1357_9BDF);
        repeat (8) @(negedge clk);
        chk("drain_queue", 32'(q.size()), 32'd0);
        chk("drain_count", 32'(enc_count), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
